ctoc_link_align: RTL
====================

# ctoc_link_align

Link-alignment controller for the 14-lane 5:1 chip-to-chip SERDES receive path. It runs in the RX divided-clock domain (125 MHz) and sequences the whole bring-up:
- waits for both MMCMs to lock;
- steps the RX MMCM fine phase;
- resets the ISERDESs and lets them settle;
- issues per-lane bitslip pulses against the training pattern until all lanes are aligned;
- releases the RX clock-crossing FIFO and declares the link up.

After bring-up it keeps supervising the link: it handles loss of lock, retrain requests and single manual phase-increment requests.

## Interface
Parameters:
- LANES, 14, number of serial lanes
- SB, 5, bits per lane per divided-clock cycle
- TRAIN_PAT, 5'h01, expected per-lane word during training
- PHASE_STEPS, 57, MMCM fine-phase steps issued after lock (0 = skip)
- PS_TIMEOUT, 63, max cycles to wait for psdone per step
- LOCK_STABLE, 16, consecutive locked cycles required before starting
- SRST_CYCLES, 8, ISERDES reset pulse length
- SETTLE_CYCLES, 1023, wait after ISERDES reset before first check
- PAUSE_CYCLES, 7, wait after each check/bitslip
- MATCH_CNT, 4, consecutive all-lane matches required for link up
- MAX_ATTEMPTS, 10, failing checks allowed before declaring failure

Ports:
- clk  in  1  RX divided clock (clk_125M_in)
- rst  in  1  synchronous, active-high reset
- mmcm_locked  in  1  RX MMCM lock (already in clk domain)
- peer_locked  in  1  TX MMCM lock, asynchronous; 2-FF synchronized internally
- psdone  in  1  MMCM phase-shift done
- psen  out  1  MMCM phase-shift enable, 1-cycle pulse
- psincdec  out  1  tied 1 (increment)
- data_in  in  LANES*SB  ISERDES parallel outputs; lane i = data_in[i*SB +: SB]
- retrain  in  1  1-cycle request to realign without re-phasing
- phase_inc  in  1  asynchronous level; rising edge requests one extra psen step
- serdes_rst  out  LANES  ISERDES reset, replicated per lane (fanout)
- fifo_rst  out  1  RX CDC FIFO reset
- bitslip  out  LANES  per-lane bitslip, 1-cycle pulses
- lane_aligned  out  LANES  lane matched TRAIN_PAT at last check
- link_up  out  1  alignment complete
- align_fail  out  1  sticky failure flag

## Operation
- All outputs are registered.
- Reset values:
  - serdes_rst = all ones, fifo_rst = 1
  - psen = 0, bitslip = 0, lane_aligned = 0
  - link_up = 0, align_fail = 0
  - state = WAIT_LOCK, all counters 0
- lock_ok = mmcm_locked & peer_locked_sync.
- States:
  - **WAIT_LOCK**: serdes_rst = 1s, fifo_rst = 1. Counts consecutive lock_ok cycles; any drop restarts the count at 0. At LOCK_STABLE goes to PHASE with step_cnt = 0.
  - **PHASE**: if step_cnt == PHASE_STEPS, goes to SERDES_RST. Otherwise drives psen = 1 for one cycle, clears the timer and goes to PS_WAIT.
  - **PS_WAIT**: on psdone, step_cnt++ and goes to PHASE. If the timer reaches PS_TIMEOUT without psdone, sets align_fail and goes to FAIL.
  - **SERDES_RST**: serdes_rst = 1s for SRST_CYCLES, then 0s; goes to SETTLE.
  - **SETTLE**: waits SETTLE_CYCLES, then clears attempt and good_cnt and goes to CHECK.
  - **CHECK** (1 cycle): each lane i is compared to TRAIN_PAT.
    - Match: lane_aligned[i] = 1.
    - Mismatch: lane_aligned[i] = 0 and bitslip[i] = 1.
    - All lanes match: good_cnt++; if good_cnt reaches MATCH_CNT, goes to UP.
    - Any mismatch: good_cnt = 0 and attempt++; if attempt reaches MAX_ATTEMPTS, sets align_fail and goes to FAIL.
    - Otherwise goes to PAUSE.
  - **PAUSE**: waits PAUSE_CYCLES, then goes to CHECK.
  - **UP**: link_up = 1, fifo_rst = 0, serdes_rst = 0s. A rising edge of phase_inc (after 2-FF sync) gives exactly one psen pulse; the controller does not wait for psdone and the link stays up.
  - **FAIL**: link_up = 0, fifo_rst = 1, serdes_rst = 0s, align_fail held.
- Global priority, evaluated every cycle: lock loss > retrain > phase_inc > state logic.
  - **Lock loss** (lock_ok = 0) in any state other than WAIT_LOCK: goes to WAIT_LOCK with a full re-phase, because MMCM relock resets the phase. link_up is cleared; lane_aligned is cleared.
  - **Retrain** in any state other than WAIT_LOCK: goes to SERDES_RST without re-phasing. Clears align_fail, link_up and lane_aligned; fifo_rst is driven 1.
  - **retrain in WAIT_LOCK**: ignored.
  - **phase_inc edge outside UP**: ignored.
- Counter widths are sized to the parameter maxima; no counter wraps, since every counter saturates or is cleared on its state exit.

## Timing
- psen: high exactly 1 cycle, on the cycle after entering PHASE. The next psen comes no earlier than 2 cycles after psdone.
- bitslip: asserted in the cycle after the CHECK cycle, for 1 cycle. data_in is sampled in the CHECK cycle.
- Bitslip pulses on the same lane are spaced by at least PAUSE_CYCLES + 1 cycles.
- link_up rises 1 cycle after the CHECK that reached MATCH_CNT. fifo_rst falls in the same cycle.
- Lock loss latency:
  - mmcm_locked drop to link_up = 0: 1 cycle.
  - peer_locked drop to link_up = 0: 3 cycles (includes the 2-FF synchronizer).
- phase_inc edge to psen: 3 cycles (2-FF sync + edge detect).
- Total bring-up with zero bitslips is approximately LOCK_STABLE + PHASE_STEPS×(psdone latency+2) + SRST_CYCLES + SETTLE_CYCLES + MATCH_CNT×(PAUSE_CYCLES+2).

## Test plan
Bench parameters: PHASE_STEPS = 3, SETTLE_CYCLES = 20, psdone model returns 4 cycles after psen.

1. **Clean bring-up.** Assert both locks; data_in = all lanes 5'h01. Expect:
   - exactly 3 psen pulses;
   - serdes_rst low after 8 cycles;
   - no bitslip;
   - link_up = 1 after 4 checks, lane_aligned = 14'h3fff, fifo_rst = 0.
2. **Misaligned lanes.** Lane 3 is rotated by 2 and lane 9 by 4; the model rotates the lane on each bitslip. Expect:
   - bitslip[3] pulsed 3 times and bitslip[9] pulsed once;
   - no other lane slipped;
   - link_up = 1.
3. **Stuck lane.** Lane 0 is stuck at 5'h00. Expect 10 bitslip[0] pulses, then align_fail = 1 and link_up = 0. A retrain pulse clears align_fail and restarts the sequence from SERDES_RST with no psen.
4. **psdone timeout.** psdone is never returned. Expect align_fail = 1 exactly 63 cycles after the first psen.
5. **Lock loss while UP.** Drop mmcm_locked for 1 cycle. Expect:
   - link_up = 0 on the next cycle, serdes_rst = all ones, fifo_rst = 1;
   - a full re-run that includes 3 psen pulses.
6. **Manual phase step.** With UP held, toggle phase_inc 0→1. Expect one psen pulse 3 cycles later and link_up held at 1. Repeat with phase_inc and retrain in the same cycle: expect retrain to win, with no psen pulse.

Source files
------------

// File: rtl/ctoc_link_align.sv
// Link-alignment controller for the chip-to-chip SERDES receive path.
// Sequences MMCM lock, fine-phase stepping, ISERDES reset and bitslip alignment, then supervises the link.
module ctoc_link_align #(
    parameter int             LANES         = 14,
    parameter int             SB            = 5,
    parameter logic [SB-1:0]  TRAIN_PAT     = 5'h01,
    parameter int             PHASE_STEPS   = 57,
    parameter int             PS_TIMEOUT    = 63,
    parameter int             LOCK_STABLE   = 16,
    parameter int             SRST_CYCLES   = 8,
    parameter int             SETTLE_CYCLES = 1023,
    parameter int             PAUSE_CYCLES  = 7,
    parameter int             MATCH_CNT     = 4,
    parameter int             MAX_ATTEMPTS  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mmcm_locked,
    input  logic                  peer_locked,
    input  logic                  psdone,
    output logic                  psen,
    output logic                  psincdec,
    input  logic [LANES*SB-1:0]   data_in,
    input  logic                  retrain,
    input  logic                  phase_inc,
    output logic [LANES-1:0]      serdes_rst,
    output logic                  fifo_rst,
    output logic [LANES-1:0]      bitslip,
    output logic [LANES-1:0]      lane_aligned,
    output logic                  link_up,
    output logic                  align_fail
);

    localparam int CNT_MAX_A = (LOCK_STABLE > PS_TIMEOUT) ? LOCK_STABLE : PS_TIMEOUT;
    localparam int CNT_MAX_B = (SRST_CYCLES > SETTLE_CYCLES) ? SRST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX_C = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_MAX   = (CNT_MAX_C > PAUSE_CYCLES) ? CNT_MAX_C : PAUSE_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int SW        = (PHASE_STEPS > 0) ? $clog2(PHASE_STEPS + 1) : 1;
    localparam int AW        = $clog2(MAX_ATTEMPTS + 1);
    localparam int GW        = $clog2(MATCH_CNT + 1);

    typedef enum logic [3:0] {
        ST_WAIT_LOCK  = 4'd0,
        ST_PHASE      = 4'd1,
        ST_PS_WAIT    = 4'd2,
        ST_SERDES_RST = 4'd3,
        ST_SETTLE     = 4'd4,
        ST_CHECK      = 4'd5,
        ST_PAUSE      = 4'd6,
        ST_UP         = 4'd7,
        ST_FAIL       = 4'd8
    } state_t;

    state_t             state_r;
    state_t             state_nx;
    logic [CW-1:0]      cnt_r;
    logic               cnt_clr_s;
    logic [SW-1:0]      step_r;
    logic [SW-1:0]      step_nx;
    logic [AW-1:0]      attempt_r;
    logic [AW-1:0]      attempt_nx;
    logic [GW-1:0]      good_r;
    logic [GW-1:0]      good_nx;

    logic               peer_meta_r;
    logic               peer_sync_r;
    logic               phinc_meta_r;
    logic               phinc_sync_r;
    logic               phinc_prev_r;
    logic               lock_ok_s;
    logic               phinc_edge_s;

    logic [LANES-1:0]   match_s;
    logic               srst_hold_s;

    logic               psen_r;
    logic               psen_nx;
    logic [LANES-1:0]   bitslip_r;
    logic [LANES-1:0]   bitslip_nx;
    logic [LANES-1:0]   lane_aligned_r;
    logic [LANES-1:0]   lane_aligned_nx;
    logic               align_fail_r;
    logic               align_fail_nx;
    logic [LANES-1:0]   serdes_rst_r;
    logic               fifo_rst_r;
    logic               link_up_r;

    assign lock_ok_s    = mmcm_locked & peer_sync_r;
    assign phinc_edge_s = phinc_sync_r & ~phinc_prev_r;

    assign psen         = psen_r;
    assign psincdec     = 1'b1;
    assign serdes_rst   = serdes_rst_r;
    assign fifo_rst     = fifo_rst_r;
    assign bitslip      = bitslip_r;
    assign lane_aligned = lane_aligned_r;
    assign link_up      = link_up_r;
    assign align_fail   = align_fail_r;

    // Two-flop synchronizers for peer lock and phase_inc, plus phase_inc edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            peer_meta_r  <= 1'b0;
            peer_sync_r  <= 1'b0;
            phinc_meta_r <= 1'b0;
            phinc_sync_r <= 1'b0;
            phinc_prev_r <= 1'b0;
        end else begin
            peer_meta_r  <= peer_locked;
            peer_sync_r  <= peer_meta_r;
            phinc_meta_r <= phase_inc;
            phinc_sync_r <= phinc_meta_r;
            phinc_prev_r <= phinc_sync_r;
        end
    end

    // Per-lane comparison against the training word
    always_comb begin
        match_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            match_s[i] = (data_in[i*SB +: SB] == TRAIN_PAT);
        end
    end

    // Next-state and next-output logic; lock loss beats retrain beats phase_inc
    always_comb begin
        state_nx        = state_r;
        cnt_clr_s       = 1'b0;
        step_nx         = step_r;
        attempt_nx      = attempt_r;
        good_nx         = good_r;
        psen_nx         = 1'b0;
        bitslip_nx      = {LANES{1'b0}};
        lane_aligned_nx = lane_aligned_r;
        align_fail_nx   = align_fail_r;

        if (!lock_ok_s && (state_r != ST_WAIT_LOCK)) begin
            state_nx        = ST_WAIT_LOCK;
            lane_aligned_nx = {LANES{1'b0}};
        end else if (retrain && (state_r != ST_WAIT_LOCK)) begin
            // Re-entry into SERDES_RST from itself must still restart the pulse
            state_nx        = ST_SERDES_RST;
            cnt_clr_s       = 1'b1;
            align_fail_nx   = 1'b0;
            lane_aligned_nx = {LANES{1'b0}};
        end else if (phinc_edge_s && (state_r == ST_UP)) begin
            psen_nx = 1'b1;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    if (!lock_ok_s) begin
                        cnt_clr_s = 1'b1;
                    end else if (cnt_r == CW'(LOCK_STABLE - 1)) begin
                        state_nx = ST_PHASE;
                        step_nx  = {SW{1'b0}};
                    end else begin
                        state_nx = ST_WAIT_LOCK;
                    end
                end
                ST_PHASE: begin
                    if (step_r == SW'(PHASE_STEPS)) begin
                        state_nx = ST_SERDES_RST;
                    end else begin
                        psen_nx  = 1'b1;
                        state_nx = ST_PS_WAIT;
                    end
                end
                ST_PS_WAIT: begin
                    if (psdone) begin
                        step_nx  = step_r + SW'(1);
                        state_nx = ST_PHASE;
                    end else if (cnt_r == CW'(PS_TIMEOUT - 1)) begin
                        align_fail_nx = 1'b1;
                        state_nx      = ST_FAIL;
                    end else begin
                        state_nx = ST_PS_WAIT;
                    end
                end
                ST_SERDES_RST: begin
                    if (cnt_r == CW'(SRST_CYCLES - 1)) begin
                        state_nx = ST_SETTLE;
                    end else begin
                        state_nx = ST_SERDES_RST;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == CW'(SETTLE_CYCLES - 1)) begin
                        attempt_nx = {AW{1'b0}};
                        good_nx    = {GW{1'b0}};
                        state_nx   = ST_CHECK;
                    end else begin
                        state_nx = ST_SETTLE;
                    end
                end
                ST_CHECK: begin
                    lane_aligned_nx = match_s;
                    bitslip_nx      = ~match_s;
                    if (&match_s) begin
                        if (good_r == GW'(MATCH_CNT - 1)) begin
                            good_nx  = GW'(MATCH_CNT);
                            state_nx = ST_UP;
                        end else begin
                            good_nx  = good_r + GW'(1);
                            state_nx = ST_PAUSE;
                        end
                    end else begin
                        good_nx = {GW{1'b0}};
                        if (attempt_r == AW'(MAX_ATTEMPTS - 1)) begin
                            attempt_nx    = AW'(MAX_ATTEMPTS);
                            align_fail_nx = 1'b1;
                            state_nx      = ST_FAIL;
                        end else begin
                            attempt_nx = attempt_r + AW'(1);
                            state_nx   = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (cnt_r == CW'(PAUSE_CYCLES - 1)) begin
                        state_nx = ST_CHECK;
                    end else begin
                        state_nx = ST_PAUSE;
                    end
                end
                ST_UP: begin
                    state_nx = ST_UP;
                end
                ST_FAIL: begin
                    state_nx = ST_FAIL;
                end
                default: begin
                    state_nx = ST_WAIT_LOCK;
                end
            endcase
        end

        cnt_clr_s = cnt_clr_s | (state_nx != state_r);
    end

    // ISERDES stays in reset from lock wait through the end of the reset pulse
    always_comb begin
        case (state_nx)
            ST_WAIT_LOCK, ST_PHASE, ST_PS_WAIT, ST_SERDES_RST: srst_hold_s = 1'b1;
            default:                                            srst_hold_s = 1'b0;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_WAIT_LOCK;
            cnt_r          <= {CW{1'b0}};
            step_r         <= {SW{1'b0}};
            attempt_r      <= {AW{1'b0}};
            good_r         <= {GW{1'b0}};
            psen_r         <= 1'b0;
            bitslip_r      <= {LANES{1'b0}};
            lane_aligned_r <= {LANES{1'b0}};
            align_fail_r   <= 1'b0;
            serdes_rst_r   <= {LANES{1'b1}};
            fifo_rst_r     <= 1'b1;
            link_up_r      <= 1'b0;
        end else begin
            state_r <= state_nx;
            if (cnt_clr_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r != {CW{1'b1}}) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            step_r         <= step_nx;
            attempt_r      <= attempt_nx;
            good_r         <= good_nx;
            psen_r         <= psen_nx;
            bitslip_r      <= bitslip_nx;
            lane_aligned_r <= lane_aligned_nx;
            align_fail_r   <= align_fail_nx;
            serdes_rst_r   <= srst_hold_s ? {LANES{1'b1}} : {LANES{1'b0}};
            fifo_rst_r     <= (state_nx != ST_UP);
            link_up_r      <= (state_nx == ST_UP);
        end
    end

endmodule
